// File: rtl/bram_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Package : bram_rd_pkg
//  Shared types and constants for the BRAM read initiator.
//  Rev     : 1.0
// ============================================================================
package bram_rd_pkg;

    localparam int WORD_BYTES  = 4;
    localparam int BRAM_ADDR_W = 32;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Byte addresses are word aligned by clearing the two low bits.
    function automatic logic [BRAM_ADDR_W-1:0] word_align(input logic [BRAM_ADDR_W-1:0] addr);
        return {addr[BRAM_ADDR_W-1:2], 2'b00};
    endfunction

endpackage : bram_rd_pkg
`default_nettype wire

// File: rtl/bram_rd_master_if.sv
`default_nettype none
// ============================================================================
//  Interface : bram_rd_master_if
//  BRAM port plus valid/ready output stream of the BRAM read initiator.
//  Rev       : 1.0
// ============================================================================
interface bram_rd_master_if;
    import bram_rd_pkg::*;

    logic [BRAM_ADDR_W-1:0] bram_addr;
    logic                   bram_en;
    logic [3:0]             bram_wen;
    logic [DATA_W-1:0]      bram_din;
    logic [DATA_W-1:0]      bram_dout;
    logic [DATA_W-1:0]      m_data;
    logic                   m_valid;
    logic                   m_ready;

    modport master (
        output bram_addr, bram_en, bram_wen, bram_din, m_data, m_valid,
        input  bram_dout, m_ready
    );

    modport slave (
        input  bram_addr, bram_en, bram_wen, bram_din, m_data, m_valid,
        output bram_dout, m_ready
    );

endinterface : bram_rd_master_if
`default_nettype wire

// File: rtl/bram_rd_fifo.sv
`default_nettype none
// ============================================================================
//  Module : bram_rd_fifo
//  Synchronous DEPTH x DATA_W FIFO with occupancy count; same-cycle push+pop.
//  Rev    : 1.0
// ============================================================================
module bram_rd_fifo
    import bram_rd_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int WIDTH   = DATA_W,
    parameter int COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head,
    output logic               empty,
    output logic [COUNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [COUNT_W-1:0] c_depth = COUNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               w_full;
    logic               w_pop;

    assign empty  = (r_count == '0);
    assign w_full = (r_count == c_depth);
    assign w_pop  = pop && !empty;
    assign count  = r_count;
    // Head reads as zero while empty so the stream data is clean after reset.
    assign head   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({push, w_pop})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && w_full && !w_pop))
        else $error("bram_rd_fifo: push into full FIFO");

endmodule : bram_rd_fifo
`default_nettype wire

// File: rtl/bram_rd_master.sv
`default_nettype none
// ============================================================================
//  Module : bram_rd_master
//  Reads num_words consecutive BRAM words from base_addr and streams them out.
//  Option : define BRAM_RD_STRIDE_EN to add a word-stride input.
//  Rev    : 1.0
// ============================================================================
module bram_rd_master
    import bram_rd_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BRAM_ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]       num_words,
`ifdef BRAM_RD_STRIDE_EN
    input  logic [15:0]            stride,
`endif
    output logic                   busy,
    output logic                   done,
    bram_rd_master_if.master       bus
);

    localparam int FC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FC_W:0] c_depth = (FC_W + 1)'(FIFO_DEPTH);

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_inflight;
    logic [BRAM_ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]       r_issued;
    logic [CNT_W-1:0]       r_num;
`ifdef BRAM_RD_STRIDE_EN
    logic [15:0]            r_stride;
`endif

    logic [FC_W-1:0]        w_fifo_count;
    logic                   w_fifo_empty;
    logic [DATA_W-1:0]      w_fifo_head;
    logic                   w_pop;
    logic [FC_W:0]          w_occ;
    logic                   w_issue;
    logic                   w_last_issue;
    logic                   w_last_pop;
    logic [BRAM_ADDR_W-1:0] w_step;

    bram_rd_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (DATA_W),
        .COUNT_W (FC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (bus.bram_dout),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign bus.m_valid = !w_fifo_empty;
    assign bus.m_data  = w_fifo_head;
    assign w_pop       = bus.m_valid && bus.m_ready;

    // Slots already claimed once this cycle's pop frees one; a new read may
    // only be issued if its word is guaranteed a FIFO entry on arrival.
    assign w_occ = {1'b0, w_fifo_count}
                 + {{FC_W{1'b0}}, r_inflight}
                 - {{FC_W{1'b0}}, w_pop};

    assign w_issue      = (r_state == RUN) && (r_issued < r_num) && (w_occ < c_depth);
    assign w_last_issue = w_issue && (r_issued == r_num - CNT_W'(1));
    assign w_last_pop   = w_pop && (w_fifo_count == FC_W'(1)) && !r_inflight;

`ifdef BRAM_RD_STRIDE_EN
    assign w_step = BRAM_ADDR_W'({r_stride, 2'b00});
`else
    assign w_step = BRAM_ADDR_W'(WORD_BYTES);
`endif

    assign bus.bram_en   = w_issue;
    assign bus.bram_addr = r_addr;
    assign bus.bram_wen  = 4'b0000;
    assign bus.bram_din  = '0;
    assign busy          = r_busy;
    assign done          = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= 1'b0;
            r_addr     <= '0;
            r_issued   <= '0;
            r_num      <= '0;
`ifdef BRAM_RD_STRIDE_EN
            r_stride   <= '0;
`endif
        end else begin
            // Read data returns one cycle after the strobe and is pushed then.
            r_inflight <= w_issue;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr   <= word_align(base_addr);
                        r_num    <= num_words;
                        r_issued <= '0;
`ifdef BRAM_RD_STRIDE_EN
                        r_stride <= stride;
`endif
                        r_busy   <= 1'b1;
                        if (num_words == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_addr   <= r_addr + w_step;
                        r_issued <= r_issued + CNT_W'(1);
                    end
                    if (w_last_issue) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    a_issue_bound : assert property (@(posedge clk) disable iff (rst) bus.bram_en |-> (r_issued < r_num))
        else $error("bram_rd_master: read issued beyond num_words");

endmodule : bram_rd_master
`default_nettype wire
